// File: rtl/lcd_display_driver.sv
// HD44780 16x2 character-LCD driver: power-up wait, one-shot init, then continuous
// two-line refresh from a combinational string ROM with hex-nibble to ASCII conversion.
module lcd_display_driver #(
    parameter int TICK_DIV      = 50000,
    parameter int POWERUP_TICKS = 20
) (
    input  logic       clk_50Mhz,
    input  logic       resetn,
    output logic [4:0] char_index,
    input  logic [7:0] char_in,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on,
    output logic       frame_done
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = (POWERUP_TICKS > 15) ? $clog2(POWERUP_TICKS + 1) : 4;

    typedef enum logic [2:0] {S_POWERUP, S_INIT, S_LINE1, S_L2ADDR, S_LINE2, S_HOME} state_t;
    typedef enum logic [1:0] {PH_ADDR, PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

    logic [TW-1:0] tick_cnt_q;
    logic          tick;
    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    char_index_q, char_index_d;
    logic [7:0]    lcd_data_q, lcd_data_d;
    logic          lcd_rs_q, lcd_rs_d;
    logic          lcd_en_q, lcd_en_d;
    logic          lcd_on_q;
    logic          frame_done_q, frame_done_d;
    logic [3:0]    col_next;

    function automatic logic [7:0] nib_to_ascii(input logic [7:0] c);
        if (c[7:4] != 4'h0) return c;
        else if (c[3:0] <= 4'd9) return 8'h30 + c;
        else return 8'h37 + c;
    endfunction

    function automatic logic [7:0] init_cmd(input logic [2:0] i);
        case (i)
            3'd0:    return 8'h38;
            3'd1:    return 8'h0C;
            3'd2:    return 8'h01;
            3'd3:    return 8'h06;
            default: return 8'h80;
        endcase
    endfunction

    assign tick     = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign col_next = cnt_q[3:0] + 4'd1;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        char_index_d = char_index_q;
        lcd_data_d   = lcd_data_q;
        lcd_rs_d     = lcd_rs_q;
        lcd_en_d     = lcd_en_q;
        frame_done_d = 1'b0;
        if (tick) begin
            if (state_q == S_POWERUP) begin
                if (cnt_q == CW'(POWERUP_TICKS)) begin
                    state_d = S_INIT;
                    phase_d = PH_ADDR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                case (phase_q)
                    PH_ADDR: begin
                        phase_d = PH_SETUP;
                        case (state_q)
                            S_INIT: begin
                                lcd_data_d = init_cmd(cnt_q[2:0]);
                                lcd_rs_d   = 1'b0;
                            end
                            S_LINE1, S_LINE2: begin
                                lcd_data_d = nib_to_ascii(char_in);
                                lcd_rs_d   = 1'b1;
                            end
                            S_L2ADDR: begin
                                lcd_data_d = 8'hC0;
                                lcd_rs_d   = 1'b0;
                            end
                            default: begin
                                lcd_data_d = 8'h80;
                                lcd_rs_d   = 1'b0;
                            end
                        endcase
                    end
                    PH_SETUP: begin
                        phase_d  = PH_PULSE;
                        lcd_en_d = 1'b1;
                    end
                    PH_PULSE: begin
                        phase_d  = PH_HOLD;
                        lcd_en_d = 1'b0;
                    end
                    default: begin
                        // Leaving HOLD selects the next byte; data states present their index now.
                        phase_d = PH_ADDR;
                        cnt_d   = cnt_q + 1'b1;
                        case (state_q)
                            S_INIT: begin
                                if (cnt_q[2:0] == 3'd4) begin
                                    state_d      = S_LINE1;
                                    cnt_d        = '0;
                                    char_index_d = 5'h00;
                                end
                            end
                            S_LINE1: begin
                                if (cnt_q[3:0] == 4'hF) begin
                                    state_d = S_L2ADDR;
                                    cnt_d   = '0;
                                end else begin
                                    char_index_d = {1'b0, col_next};
                                end
                            end
                            S_L2ADDR: begin
                                state_d      = S_LINE2;
                                cnt_d        = '0;
                                char_index_d = 5'h10;
                            end
                            S_LINE2: begin
                                if (cnt_q[3:0] == 4'hF) begin
                                    state_d      = S_HOME;
                                    cnt_d        = '0;
                                    frame_done_d = 1'b1;
                                end else begin
                                    char_index_d = {1'b1, col_next};
                                end
                            end
                            default: begin
                                state_d      = S_LINE1;
                                cnt_d        = '0;
                                char_index_d = 5'h00;
                            end
                        endcase
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_50Mhz or negedge resetn) begin
        if (!resetn) begin
            tick_cnt_q   <= '0;
            state_q      <= S_POWERUP;
            phase_q      <= PH_ADDR;
            cnt_q        <= '0;
            char_index_q <= 5'h00;
            lcd_data_q   <= 8'h00;
            lcd_rs_q     <= 1'b0;
            lcd_en_q     <= 1'b0;
            lcd_on_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            tick_cnt_q   <= tick ? '0 : tick_cnt_q + 1'b1;
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            char_index_q <= char_index_d;
            lcd_data_q   <= lcd_data_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_en_q     <= lcd_en_d;
            lcd_on_q     <= 1'b1;
            frame_done_q <= frame_done_d;
        end
    end

    assign char_index = char_index_q;
    assign lcd_data   = lcd_data_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_en     = lcd_en_q;
    assign lcd_on     = lcd_on_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_display_driver.sv
// Scoreboard bench for lcd_display_driver: expected {rs,data} bytes are queued by the
// stimulus process and consumed by a monitor on every lcd_en falling edge.
module tb_lcd_display_driver;
    localparam int TD = 4;
    localparam int PT = 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [4:0] char_index;
    logic [7:0] char_in;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_on, frame_done;

    logic [7:0] rom [32];
    logic [8:0] exp_q [$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         rel_cyc = 0;
    string      hexchars = "0123456789ABCDEF";

    assign char_in = rom[char_index];

    lcd_display_driver #(.TICK_DIV(TD), .POWERUP_TICKS(PT)) dut (
        .clk_50Mhz (clk),
        .resetn    (resetn),
        .char_index(char_index),
        .char_in   (char_in),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_on    (lcd_on),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Raw values below 0x10 are hex digits shown as ASCII; anything else is already a character.
    function automatic logic [7:0] model_char(input logic [7:0] v);
        if (v < 8'h10) return hexchars[v[3:0]];
        return v;
    endfunction

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h80});
    endtask

    task automatic push_frame(input bit with_home);
        if (with_home) exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, model_char(rom[i])});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, model_char(rom[i])});
    endtask

    task automatic wait_fd();
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL frame_done_timeout: actual none required pulse within 2000 clks");
            finish_tb();
        end
    endtask

    // Monitor: byte capture, strobe timing, data stability and frame_done shape.
    bit         prev_en = 0, prev_fd = 0, first_rise = 1, have_fall = 0, have_fd = 0;
    logic [8:0] prev_bus = '0;
    int         last_chg = 0, last_rise = 0, last_fall = 0, last_fd = 0;

    always @(negedge clk) begin
        cyc++;
        if (!resetn) begin
            prev_en    = 0;
            prev_fd    = 0;
            first_rise = 1;
            have_fall  = 0;
            have_fd    = 0;
            prev_bus   = {lcd_rs, lcd_data};
            last_chg   = cyc;
        end else begin
            if ({lcd_rs, lcd_data} != prev_bus) begin
                last_chg = cyc;
                if (have_fall) check_rng("data_hold_after_fall", cyc - last_fall, TD, 1 << 30);
            end
            if (lcd_en && !prev_en) begin
                check_rng("data_setup_before_rise", cyc - last_chg, TD, 1 << 30);
                if (first_rise)
                    check_rng("first_rise_window", cyc - rel_cyc, (PT + 2) * TD, (PT + 4) * TD);
                else
                    check_eq("rise_period", cyc - last_rise, 4 * TD);
                first_rise = 0;
                last_rise  = cyc;
            end
            if (!lcd_en && prev_en) begin
                check_eq("en_high_clks", cyc - last_rise, TD);
                last_fall = cyc;
                have_fall = 1;
                check_eq("lcd_rw", lcd_rw, 0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL capture_unexpected: actual %0h required none", {lcd_rs, lcd_data});
                end else begin
                    check_eq("capture", {lcd_rs, lcd_data}, exp_q.pop_front());
                end
            end
            if (prev_fd) check_eq("frame_done_width", frame_done, 0);
            if (frame_done && !prev_fd) begin
                if (have_fd) check_eq("frame_period", cyc - last_fd, 136 * TD);
                have_fd = 1;
                last_fd = cyc;
            end
            prev_en  = lcd_en;
            prev_fd  = frame_done;
            prev_bus = {lcd_rs, lcd_data};
        end
    end

    initial begin
        rom[0] = 8'h43; rom[1] = 8'h6F; rom[2] = 8'h75; rom[3] = 8'h6E;
        rom[4] = 8'h74; rom[5] = 8'h3D; rom[6] = 8'h0A; rom[7] = 8'h05;
        for (int i = 8; i < 32; i++) rom[i] = 8'h20;
        rom[16] = 8'h44; rom[17] = 8'h45; rom[18] = 8'h32;

        resetn = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check_eq("reset_outputs",
                     {char_index, lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, frame_done}, 0);
        end
        push_init();
        push_frame(0);
        #1 resetn = 1'b1;
        rel_cyc = cyc;
        @(negedge clk);
        check_eq("lcd_on_after_release", lcd_on, 1);

        for (int f = 0; f < 7; f++) begin
            wait_fd();
            check_eq("queue_drained_at_frame_done", exp_q.size(), 0);
            if (f == 0) rom[7] = 8'h09;
            else if (f == 1) rom[7] = 8'h0F;
            else begin
                rom[6]  = 8'($urandom_range(0, 15));
                rom[7]  = 8'($urandom_range(0, 15));
                rom[31] = 8'($urandom_range(0, 255));
            end
            push_frame(1);
        end

        begin
            bit seen = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (lcd_en) begin
                    seen = 1;
                    break;
                end
            end
            check_eq("pulse_seen_before_reset", seen, 1);
        end
        #1 resetn = 1'b0;
        #1;
        check_eq("async_reset_en", lcd_en, 0);
        check_eq("async_reset_idx_data", {char_index, lcd_data, lcd_rs}, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        push_init();
        push_frame(0);
        #1 resetn = 1'b1;
        rel_cyc = cyc;
        wait_fd();
        check_eq("queue_drained_after_reset", exp_q.size(), 0);
        finish_tb();
    end

endmodule
